// File: rtl/alu_pkg.sv
// Shared op encoding, FSM state type and op decode helper for the bit-serial ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } alu_state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_slice_1b.sv
// One-bit ALU slice: full adder (b inverted for sub) plus and/or/xor; illegal ops yield 0.
module alu_slice_1b
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       res,
    output logic       cout
);

    logic b_eff_s;
    logic sum_s;

    // Slice datapath: adder terms and result mux.
    always_comb begin
        b_eff_s = (op == OP_SUB) ? ~b : b;
        sum_s   = a ^ b_eff_s ^ cin;
        cout    = (a & b_eff_s) | (cin & (a ^ b_eff_s));
        case (op)
            OP_ADD, OP_SUB: res = sum_s;
            OP_AND:         res = a & b;
            OP_OR:          res = a | b;
            OP_XOR:         res = a ^ b;
            default:        res = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: runs one alu_slice_1b LSB-first for WIDTH cycles,
// chaining the carry through a register, then publishes result and flags.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_flag,
    output logic             illegal_op
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    alu_state_t       state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;

    logic             slice_res_s;
    logic             slice_cout_s;
    logic [WIDTH-1:0] res_next_s;

    alu_slice_1b u_slice (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .op   (op_r),
        .res  (slice_res_s),
        .cout (slice_cout_s)
    );

    // Shift register contents after the current RUN cycle; used to publish on the last bit.
    always_comb begin
        res_next_s = {slice_res_s, res_sh_r[WIDTH-1:1]};
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            a_sh_r     <= '0;
            b_sh_r     <= '0;
            res_sh_r   <= '0;
            op_r       <= 3'b000;
            cnt_r      <= '0;
            carry_r    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry_out  <= 1'b0;
            zero_flag  <= 1'b1;
            illegal_op <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        op_r    <= op;
                        cnt_r   <= '0;
                        carry_r <= (op == OP_SUB);
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= a_sh_r >> 1;
                    b_sh_r   <= b_sh_r >> 1;
                    res_sh_r <= res_next_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (op_is_arith(op_r)) begin
                        carry_r <= slice_cout_s;
                    end else begin
                        carry_r <= carry_r;
                    end
                    // Outputs are loaded with the final bit so they are valid in the done cycle.
                    if (cnt_r == CNT_LAST) begin
                        result     <= res_next_s;
                        carry_out  <= op_is_arith(op_r) ? slice_cout_s : 1'b0;
                        zero_flag  <= ~|res_next_s;
                        illegal_op <= ~op_is_legal(op_r);
                        done       <= 1'b1;
                        state_r    <= ST_FIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8): directed spec cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero_flag;
    logic         illegal_op;

    int checks   = 0;
    int failures = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out),
        .zero_flag  (zero_flag),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic ill);
        int unsigned xi, yi, s;
        xi = x;
        yi = y;
        c   = 1'b0;
        ill = 1'b0;
        case (o)
            3'b000: begin s = xi + yi; r = W'(s % 256); c = (s >= 256); end
            3'b001: begin r = W'((xi + 256 - yi) % 256); c = (xi >= yi); end
            3'b010: r = x & y;
            3'b100: r = x | y;
            3'b110: r = x ^ y;
            default: begin r = '0; ill = 1'b1; end
        endcase
    endtask

    // Issue one op, optionally disturbing start/a/b/op mid-RUN, and check everything at done.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit disturb);
        logic [W-1:0] er;
        logic ec, eill;
        int n;
        int extra;
        bit got;
        model(o, x, y, er, ec, eill);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            if (disturb && n == 3) begin
                start = 1'b1;
                a = ~x;
                b = W'($urandom);
                op = 3'($urandom);
            end
            if (n == 1) check("busy_after_start", busy, 1'b1);
            if (done) got = 1'b1;
        end
        check("done_seen", got, 1'b1);
        check("latency", n, W + 1);
        check("result", result, er);
        check("carry_out", carry_out, ec);
        check("zero_flag", zero_flag, (er == '0));
        check("illegal_op", illegal_op, eill);
        check("busy_at_done", busy, 1'b1);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("busy_cleared", busy, 1'b0);
        if (disturb) begin
            extra = 0;
            for (int i = 0; i < 2 * (W + 2); i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("no_extra_done", extra, 0);
            check("result_held", result, er);
        end
    endtask

    initial begin
        logic [2:0] rop;
        int dn;
        rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, '0);
        check("rst_zero", zero_flag, 1'b1);
        check("rst_carry", carry_out, 1'b0);
        check("rst_illegal", illegal_op, 1'b0);

        // Directed cases
        run_op(3'b000, 8'hFF, 8'h01, 1'b0);
        run_op(3'b001, 8'h05, 8'h07, 1'b0);
        run_op(3'b001, 8'h07, 8'h07, 1'b0);
        run_op(3'b010, 8'hC3, 8'hA5, 1'b0);
        run_op(3'b100, 8'hC3, 8'hA5, 1'b0);
        run_op(3'b110, 8'hC3, 8'hA5, 1'b0);
        run_op(3'b011, 8'h12, 8'h34, 1'b0);
        run_op(3'b000, 8'h03, 8'h04, 1'b0);

        // Mid-RUN start and operand changes must not disturb the op in flight
        run_op(3'b000, 8'h5A, 8'h3C, 1'b1);
        run_op(3'b001, 8'h10, 8'hF0, 1'b1);

        // Reset during RUN: no done, outputs back to reset values, then normal op
        @(negedge clk);
        op = 3'b000; a = 8'h77; b = 8'h11; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_result", result, '0);
        check("midrst_zero", zero_flag, 1'b1);
        check("midrst_carry", carry_out, 1'b0);
        dn = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("midrst_no_done", dn, 0);
        run_op(3'b000, 8'h21, 8'h43, 1'b0);

        // Random ops, including illegal codes
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 5))
                0: rop = 3'b000;
                1: rop = 3'b001;
                2: rop = 3'b010;
                3: rop = 3'b100;
                4: rop = 3'b110;
                default: rop = 3'($urandom);
            endcase
            run_op(rop, W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
